// File: rtl/wb_cmd_master.sv
// wb_cmd_master -- turns single commands into classic Wishbone cycles.
//
// One command at a time: accept on cmd_valid & cmd_ready, run one Wishbone
// cycle (cyc_o = stb_o), reissue after rty_i with a one-cycle gap up to
// MAX_RETRY times, then hold the response until rsp_ready.
//
// Ports:
//   clk_i, reset_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready       command handshake; cmd_we/adr/dat/sel fields
//   rsp_valid/rsp_ready       response handshake; rsp_dat, rsp_status
//                             (0 ok, 1 err, 2 retry exhausted, 3 timeout)
//   cyc_o/stb_o/we_o/adr_o/dat_o/sel_o   Wishbone master outputs
//   dat_i, ack_i, err_i, rty_i           Wishbone slave inputs
//
// Optional feature: define WB_CMD_MASTER_TIMEOUT_EN to enable a bus watchdog
// that ends a cycle with status 3 after TIMEOUT_CYCLES BUS cycles with no
// termination. Without it the master waits on the slave indefinitely.

module wb_cmd_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int SELECT_WIDTH   = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH-1:0]   cmd_dat,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic [1:0]              rsp_status,
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic [SELECT_WIDTH-1:0] sel_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic                    ack_i,
    input  logic                    err_i,
    input  logic                    rty_i
);

    typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ERR     = 2'd1;
    localparam logic [1:0] ST_RTY     = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    // At least one bit so MAX_RETRY=0 still elaborates.
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    state_t        state, state_nx;
    logic [RW-1:0] retry_cnt;
    logic          retry_ok;
    logic          tmo_hit;

    assign retry_ok  = (retry_cnt < RETRY_LIM);
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign cyc_o     = (state == BUS);
    assign stb_o     = (state == BUS);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;

    // Counts completed BUS cycles of the current attempt; held at zero
    // outside BUS, so every entry into BUS starts a fresh window.
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state != BUS) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // High on the last permitted BUS cycle.
    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    // Watchdog absent: constant false, TIMEOUT_CYCLES has no effect.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Termination priority: err_i > ack_i > rty_i > watchdog.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_valid) state_nx = BUS;
            BUS: begin
                if (err_i || ack_i)  state_nx = RESP;
                else if (rty_i)      state_nx = retry_ok ? BACKOFF : RESP;
                else if (tmo_hit)    state_nx = RESP;
            end
            BACKOFF: state_nx = BUS;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            we_o       <= 1'b0;
            adr_o      <= '0;
            dat_o      <= '0;
            sel_o      <= '0;
            retry_cnt  <= '0;
            rsp_dat    <= '0;
            rsp_status <= ST_OK;
        end else begin
            if (state == IDLE && cmd_valid) begin
                // Bus fields are frozen here for the whole command.
                we_o      <= cmd_we;
                adr_o     <= cmd_adr;
                dat_o     <= cmd_dat;
                sel_o     <= cmd_sel;
                retry_cnt <= '0;
            end
            if (state == BUS) begin
                if (err_i) begin
                    rsp_status <= ST_ERR;
                    rsp_dat    <= '0;
                end else if (ack_i) begin
                    rsp_status <= ST_OK;
                    rsp_dat    <= we_o ? '0 : dat_i;
                end else if (rty_i) begin
                    if (retry_ok) begin
                        retry_cnt <= retry_cnt + 1'b1;
                    end else begin
                        rsp_status <= ST_RTY;
                        rsp_dat    <= '0;
                    end
                end else if (tmo_hit) begin
                    rsp_status <= ST_TIMEOUT;
                    rsp_dat    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

    localparam int DW = 32;
    localparam int SW = 4;
    localparam int AW = 32;
    localparam int MR = 3;
    localparam int TO = 8;

    localparam int T_ACK = 0;  // ack only
    localparam int T_ERR = 1;  // err only
    localparam int T_RTY = 2;  // rty only
    localparam int T_EA  = 3;  // err + ack together
    localparam int T_RA  = 4;  // rty + ack together
    localparam int T_SIL = 5;  // slave never answers

    logic          clk_i = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic [1:0]    rsp_status;
    logic          cyc_o, stb_o, we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_o;
    logic [DW-1:0] dat_i = '0;
    logic          ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;

    int errors = 0;
    int checks = 0;

    // Slave script for the next command: per attempt, wait states and termination.
    int n_att;
    int w [8];
    int t [8];

    wb_cmd_master #(
        .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .ADDR_WIDTH(AW),
        .MAX_RETRY(MR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat), .rsp_status(rsp_status),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: outcome of a command from the slave script alone.
    function automatic void model(output int st, output int cyc, output int gaps);
        int retries;
        retries = 0;
        st = 0; cyc = 0; gaps = 0;
        for (int a = 0; a < n_att; a++) begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            if (t[a] == T_SIL || w[a] + 1 > TO) begin
                cyc += TO; st = 3; return;
            end
`endif
            cyc += w[a] + 1;
            if (t[a] == T_ERR || t[a] == T_EA) begin st = 1; return; end
            if (t[a] == T_ACK || t[a] == T_RA) begin st = 0; return; end
            if (retries == MR) begin st = 2; return; end
            retries++;
            gaps++;
        end
    endfunction

    task automatic run_cmd(input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                           input int hold);
        logic [127:0] flds, rs;
        logic [DW-1:0] rd;
        int att, acnt, cyc, gaps, it, est, ecyc, egaps;
        att = 0; acnt = 0; cyc = 0; gaps = 0;
        model(est, ecyc, egaps);
        rd = $urandom;
        dat_i = rd;
        flds = {59'd0, we, adr, dat, sel};

        @(negedge clk_i);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(negedge clk_i);
        cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
        it = 1;
        while (!rsp_valid && it < 300) begin
            {ack_i, err_i, rty_i} = 3'b000;
            chk("cmd_ready_busy", cmd_ready, 0);
            chk("stb_eq_cyc", stb_o, cyc_o);
            if (cyc_o) begin
                chk("bus_fields", {59'd0, we_o, adr_o, dat_o, sel_o}, flds);
                cyc++; acnt++;
                if (att < n_att && t[att] != T_SIL && acnt == w[att] + 1) begin
                    case (t[att])
                        T_ACK:   ack_i = 1'b1;
                        T_ERR:   err_i = 1'b1;
                        T_RTY:   rty_i = 1'b1;
                        T_EA:    begin err_i = 1'b1; ack_i = 1'b1; end
                        default: begin rty_i = 1'b1; ack_i = 1'b1; end
                    endcase
                    att++; acnt = 0;
                end
            end else begin
                gaps++;
            end
            @(negedge clk_i);
            it++;
        end
        {ack_i, err_i, rty_i} = 3'b000;
        chk("rsp_valid_seen", rsp_valid, 1);
        chk("rsp_latency", it, ecyc + egaps + 1);
        chk("cyc_cycles", cyc, ecyc);
        chk("gap_cycles", gaps, egaps);
        chk("rsp_status", rsp_status, est);
        if (est == 0) chk("rsp_dat", rsp_dat, we ? '0 : rd);
        rs = {94'd0, rsp_status, rsp_dat};

        // Offer a new command while the response waits; it must not be taken.
        cmd_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_ready_low", cmd_ready, 0);
            chk("hold_cyc_low", cyc_o, 0);
            chk("hold_stable", {94'd0, rsp_status, rsp_dat}, rs);
            @(negedge clk_i);
        end
        rsp_ready = 1'b1;
        @(negedge clk_i);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("consumed_valid", rsp_valid, 0);
        chk("consumed_idle", cmd_ready, 1);
        chk("consumed_no_cyc", cyc_o, 0);
    endtask

    // Accept a command to a silent slave, watch n BUS cycles, then reset.
    task automatic silent_then_reset(input int n);
        n_att = 1; t[0] = T_SIL; w[0] = 0;
        @(negedge clk_i);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h100; cmd_dat = '0; cmd_sel = 4'hF;
        @(negedge clk_i);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("silent_cyc_high", cyc_o, 1);
            chk("silent_no_rsp", rsp_valid, 0);
            @(negedge clk_i);
        end
        reset_n = 1'b0;
        @(negedge clk_i);
        chk("rst_cyc_low", cyc_o, 0);
        chk("rst_no_rsp", rsp_valid, 0);
        chk("rst_adr_clr", adr_o, 0);
        @(negedge clk_i);
        chk("rst_no_rsp2", rsp_valid, 0);
        reset_n = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_no_rsp3", rsp_valid, 0);
    endtask

    initial begin
        int pick [6];
        pick = '{T_ACK, T_ERR, T_RTY, T_RTY, T_EA, T_RA};

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_stb", stb_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_fields", {adr_o, dat_o, sel_o}, 0);
        chk("rst_rsp", {rsp_valid, rsp_status, rsp_dat}, 0);
        reset_n = 1'b1;
        @(negedge clk_i);
        chk("rst_cmd_ready", cmd_ready, 1);

        // Zero-wait write
        n_att = 1; w[0] = 0; t[0] = T_ACK;
        run_cmd(1'b1, 32'h4, 32'h0000_00F0, 4'hF, 0);
        // Read with 3 wait states
        n_att = 1; w[0] = 3; t[0] = T_ACK;
        dat_i = 32'hDEAD_BEEF;
        run_cmd(1'b0, 32'h20, 32'h0, 4'hF, 1);
        // Retry exhausted
        n_att = 4;
        for (int i = 0; i < 4; i++) begin w[i] = 0; t[i] = T_RTY; end
        run_cmd(1'b0, 32'h30, 32'h0, 4'h3, 0);
        // Ack on the third attempt
        n_att = 3; w = '{0, 1, 0, 0, 0, 0, 0, 0}; t = '{T_RTY, T_RTY, T_ACK, 0, 0, 0, 0, 0};
        run_cmd(1'b0, 32'h34, 32'h0, 4'hC, 0);
        // err and ack together, long response stall
        n_att = 1; w[0] = 1; t[0] = T_EA;
        run_cmd(1'b1, 32'h40, 32'h1234_5678, 4'h1, 5);
        // Long attempts across retries: watchdog window restarts per attempt
        n_att = 3; w = '{5, 5, 5, 0, 0, 0, 0, 0}; t = '{T_RTY, T_RTY, T_ACK, 0, 0, 0, 0, 0};
        run_cmd(1'b0, 32'h44, 32'h0, 4'hF, 0);
        // Ack exactly on the watchdog limit cycle, then one past it
        n_att = 1; w[0] = TO - 1; t[0] = T_ACK;
        run_cmd(1'b0, 32'h48, 32'h0, 4'hF, 0);
        n_att = 1; w[0] = TO; t[0] = T_ACK;
        run_cmd(1'b0, 32'h4C, 32'h0, 4'hF, 0);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        n_att = 1; w[0] = 0; t[0] = T_SIL;
        run_cmd(1'b0, 32'h50, 32'h0, 4'hF, 2);
        silent_then_reset(5);
`else
        silent_then_reset(100);
`endif
        // Normal command after a mid-command reset
        n_att = 1; w[0] = 2; t[0] = T_ACK;
        run_cmd(1'b0, 32'h60, 32'h0, 4'hF, 0);

        // Randomized commands and slave behaviour
        for (int k = 0; k < 25; k++) begin
            n_att = 6;
            for (int a = 0; a < 6; a++) begin
                w[a] = $urandom_range(0, 3);
                t[a] = pick[$urandom_range(0, 5)];
            end
            run_cmd(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
